// File: rtl/clk_date_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_date_pkg
// Description : Shared calendar constants and elaboration-time helpers for
//               the digital clock date path (month encoding, year residues,
//               BCD conversion of reload constants).
// Revision    : 1.0 - initial release
// ============================================================================
package clk_date_pkg;

    localparam int MONTH_W = 4;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    localparam logic [MONTH_W-1:0] MONTH_FIRST = JAN;
    localparam logic [MONTH_W-1:0] MONTH_LAST  = DEC;

    // Residue of a year against a base; used only to build reset constants.
    function automatic int yr_residue(input int year, input int base);
        return year % base;
    endfunction

    // Four packed BCD digits (thousands..units) of a year.
    function automatic logic [15:0] to_bcd4(input int year);
        return {4'((year / 1000) % 10), 4'((year / 100) % 10),
                4'((year / 10) % 10),   4'(year % 10)};
    endfunction

endpackage : clk_date_pkg
`default_nettype wire

// File: rtl/leap_tracker.sv
`default_nettype none
// ============================================================================
// Module      : leap_tracker
// Description : Tracks year mod 4 / 100 / 400 incrementally so the Gregorian
//               leap flag needs no divider.
//   clk     in  timebase clock (rising edge)
//   reset   in  asynchronous active-high reset, loads YEAR_MIN residues
//   i_step  in  year advances by one this edge
//   i_wrap  in  year reloads YEAR_MIN this edge (qualifies i_step)
//   o_leap  out current year is a leap year
// Revision    : 1.0 - initial release
// ============================================================================
module leap_tracker
    import clk_date_pkg::*;
#(
    parameter int YEAR_MIN = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_step,
    input  logic i_wrap,
    output logic o_leap
);

    localparam logic [1:0] c_r4_init   = 2'(yr_residue(YEAR_MIN, 4));
    localparam logic [6:0] c_r100_init = 7'(yr_residue(YEAR_MIN, 100));
    localparam logic [8:0] c_r400_init = 9'(yr_residue(YEAR_MIN, 400));

    logic [1:0] r_r4;
    logic [6:0] r_r100;
    logic [8:0] r_r400;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_r4   <= c_r4_init;
            r_r100 <= c_r100_init;
            r_r400 <= c_r400_init;
        end else if (i_step) begin
            if (i_wrap) begin
                r_r4   <= c_r4_init;
                r_r100 <= c_r100_init;
                r_r400 <= c_r400_init;
            end else begin
                r_r4   <= (r_r4   == 2'd3)   ? 2'd0 : r_r4   + 2'd1;
                r_r100 <= (r_r100 == 7'd99)  ? 7'd0 : r_r100 + 7'd1;
                r_r400 <= (r_r400 == 9'd399) ? 9'd0 : r_r400 + 9'd1;
            end
        end
    end

    assign o_leap = (r_r400 == 9'd0) | ((r_r4 == 2'd0) & (r_r100 != 7'd0));

endmodule : leap_tracker
`default_nettype wire

// File: rtl/thang_nam.sv
`default_nettype none
// ============================================================================
// Module      : thang_nam
// Description : Calendar month/year stage downstream of the day counter.
//               Counts month 1..12 and year YEAR_MIN..YEAR_MAX on sig_1Hz,
//               advancing on end_month or on the set buttons, and supplies
//               the Gregorian leap flag.
//   sig_1Hz    in  timebase clock
//   reset      in  asynchronous active-high reset
//   end_month  in  day counter finished the last day of the month
//   month_b    in  set button: advance month (no year carry)
//   year_b     in  set button: advance year
//   month_o    out current month 1..12
//   year_o     out current year, binary
//   leap_year  out current year is a leap year
//   end_year   out end_month while in December (combinational)
//   year_bcd_o out BCD year when THANG_NAM_YEAR_BCD_EN is defined, else 0
// Optional    : THANG_NAM_YEAR_BCD_EN builds a BCD mirror of the year.
// Revision    : 1.0 - initial release
// ============================================================================
module thang_nam
    import clk_date_pkg::*;
#(
    parameter int YEAR_MIN = 2000,
    parameter int YEAR_MAX = 2099,
    parameter int YEAR_W   = 12
) (
    input  logic               sig_1Hz,
    input  logic               reset,
    input  logic               end_month,
    input  logic               month_b,
    input  logic               year_b,
    output logic [MONTH_W-1:0] month_o,
    output logic [YEAR_W-1:0]  year_o,
    output logic               leap_year,
    output logic               end_year,
    output logic [15:0]        year_bcd_o
);

    generate
        if (YEAR_MAX <= YEAR_MIN || YEAR_MAX > 4095 || YEAR_MAX >= (1 << YEAR_W)) begin : g_bad_range
            $error("thang_nam: illegal YEAR_MIN/YEAR_MAX/YEAR_W combination");
        end
    endgenerate

    localparam logic [YEAR_W-1:0] c_year_min = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] c_year_max = YEAR_W'(YEAR_MAX);

    logic [MONTH_W-1:0] r_month;
    logic [YEAR_W-1:0]  r_year;
    logic               w_month_adv;
    logic               w_month_last;
    logic               w_year_step;
    logic               w_year_wrap;

    assign w_month_adv  = month_b | end_month;
    assign w_month_last = (r_month == MONTH_LAST);
    // Only the day counter's rollover carries into the year; month_b never does.
    assign w_year_step  = year_b | (end_month & w_month_last);
    assign w_year_wrap  = w_year_step & (r_year == c_year_max);

    always_ff @(posedge sig_1Hz or posedge reset) begin
        if (reset) begin
            r_month <= MONTH_FIRST;
        end else if (w_month_adv) begin
            // December and any corrupted encoding both restart at January.
            if (r_month >= MONTH_LAST || r_month < MONTH_FIRST) begin
                r_month <= MONTH_FIRST;
            end else begin
                r_month <= r_month + 4'd1;
            end
        end
    end

    always_ff @(posedge sig_1Hz or posedge reset) begin
        if (reset) begin
            r_year <= c_year_min;
        end else if (w_year_step) begin
            r_year <= w_year_wrap ? c_year_min : r_year + 1'b1;
        end
    end

    leap_tracker #(
        .YEAR_MIN (YEAR_MIN)
    ) u_leap (
        .clk    (sig_1Hz),
        .reset  (reset),
        .i_step (w_year_step),
        .i_wrap (w_year_wrap),
        .o_leap (leap_year)
    );

    assign month_o  = r_month;
    assign year_o   = r_year;
    assign end_year = end_month & w_month_last;

`ifdef THANG_NAM_YEAR_BCD_EN
    localparam logic [15:0] c_bcd_min = to_bcd4(YEAR_MIN);

    logic [15:0] r_bcd;
    logic [15:0] w_bcd_inc;

    // Ripple +1 across the four digits, each digit wrapping 9 -> 0.
    always_comb begin
        logic w_carry;
        w_bcd_inc = r_bcd;
        w_carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_bcd[i*4 +: 4] == 4'd9) begin
                    w_bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sig_1Hz or posedge reset) begin
        if (reset) begin
            r_bcd <= c_bcd_min;
        end else if (w_year_step) begin
            r_bcd <= w_year_wrap ? c_bcd_min : w_bcd_inc;
        end
    end

    assign year_bcd_o = r_bcd;
`else
    assign year_bcd_o = 16'h0000;
`endif

endmodule : thang_nam
`default_nettype wire

// File: tb/tb_thang_nam.sv
`default_nettype none
// ============================================================================
// Module      : tb_thang_nam
// Description : Self-checking bench for thang_nam: table-driven month/year
//               vectors plus directed multi-cycle sequences, and a second
//               instance with a narrow year range to exercise century rules
//               and the year wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thang_nam;

    logic        clk;
    logic        reset;
    logic        end_month, month_b, year_b;
    logic [3:0]  month_o;
    logic [11:0] year_o;
    logic        leap_year, end_year;
    logic [15:0] year_bcd_o;

    logic        end_month2, month_b2, year_b2;
    logic [3:0]  month2;
    logic [11:0] year2;
    logic        leap2, end_year2;
    logic [15:0] bcd2;

    int errors = 0;
    int checks = 0;

    thang_nam dut (
        .sig_1Hz    (clk),
        .reset      (reset),
        .end_month  (end_month),
        .month_b    (month_b),
        .year_b     (year_b),
        .month_o    (month_o),
        .year_o     (year_o),
        .leap_year  (leap_year),
        .end_year   (end_year),
        .year_bcd_o (year_bcd_o)
    );

    thang_nam #(.YEAR_MIN(2096), .YEAR_MAX(2104), .YEAR_W(12)) dut2 (
        .sig_1Hz    (clk),
        .reset      (reset),
        .end_month  (end_month2),
        .month_b    (month_b2),
        .year_b     (year_b2),
        .month_o    (month2),
        .year_o     (year2),
        .leap_year  (leap2),
        .end_year   (end_year2),
        .year_bcd_o (bcd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic mb, em, yb;
        logic ey;
        int   m, y;
        logic l;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gleap(input int y);
        return ((y % 400) == 0 || ((y % 4) == 0 && (y % 100) != 0)) ? 1 : 0;
    endfunction

    function automatic int exp_bcd(input int y);
`ifdef THANG_NAM_YEAR_BCD_EN
        return ((y / 1000) % 10) * 4096 + ((y / 100) % 10) * 256 + ((y / 10) % 10) * 16 + (y % 10);
`else
        return y * 0;
`endif
    endfunction

    // Drive one edge's worth of inputs, optionally checking end_year before it.
    task automatic apply(input logic mb, input logic em, input logic yb,
                         input bit do_ey, input logic ey);
        @(negedge clk);
        month_b = mb; end_month = em; year_b = yb;
        #1;
        if (do_ey) chk("end_year_pre", int'(end_year), int'(ey));
        @(posedge clk);
        #1;
        month_b = 1'b0; end_month = 1'b0; year_b = 1'b0;
    endtask

    task automatic state(input string name, input int m, input int y, input int l);
        chk({name, ".month"}, int'(month_o), m);
        chk({name, ".year"},  int'(year_o),  y);
        chk({name, ".leap"},  int'(leap_year), l);
        chk({name, ".bcd"},   int'(year_bcd_o), exp_bcd(y));
    endtask

    initial begin
        reset = 1'b1;
        end_month = 0; month_b = 0; year_b = 0;
        end_month2 = 0; month_b2 = 0; year_b2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        state("reset", 1, 2000, 1);
        chk("reset.end_year", int'(end_year), 0);
        chk("reset2.year", int'(year2), 2096);
        chk("reset2.leap", int'(leap2), 1);

        // Month buttons 1 -> 12, then mixed events.
        for (int i = 0; i < 11; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, i + 2, 2000, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2000, 1'b1}; // wrap, no year carry
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 2000, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 2000, 1'b1}; // hold
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 2001, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 2001, 1'b0}; // advances once
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 2002, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 2003, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 2004, 1'b1};
        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].mb, tbl[i].em, tbl[i].yb, 1'b1, tbl[i].ey);
            state($sformatf("tbl%0d", i), tbl[i].m, tbl[i].y, int'(tbl[i].l));
        end

        // December rollover via end_month: 12/2023 -> 1/2024.
        repeat (19) apply(0, 0, 1, 1'b0, 1'b0);
        repeat (8)  apply(1, 0, 0, 1'b0, 1'b0);
        state("dec2023", 12, 2023, 0);
        apply(0, 1, 0, 1'b1, 1'b1);
        state("rollover", 1, 2024, 1);
        chk("end_year_after", int'(end_year), 0);

        // end_month and month_b together in December: one month, one year.
        repeat (11) apply(1, 0, 0, 1'b0, 1'b0);
        apply(1, 1, 0, 1'b1, 1'b1);
        state("em_mb_dec", 1, 2025, 0);

        // 12/2099 with end_month and year_b together: single step, wraps.
        repeat (74) apply(0, 0, 1, 1'b0, 1'b0);
        repeat (11) apply(1, 0, 0, 1'b0, 1'b0);
        state("dec2099", 12, 2099, 0);
        apply(0, 1, 1, 1'b1, 1'b1);
        state("wrap2099", 1, 2000, 1);

        // Asynchronous reset between edges from 7/2043.
        repeat (6)  apply(1, 0, 0, 1'b0, 1'b0);
        repeat (43) apply(0, 0, 1, 1'b0, 1'b0);
        state("jul2043", 7, 2043, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        state("async_rst", 1, 2000, 1);
        month_b = 1'b1; year_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        state("rst_held", 1, 2000, 1);
        month_b = 1'b0; year_b = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Narrow range instance: century rule and wrap back to YEAR_MIN.
        for (int k = 0; k <= 9; k++) begin
            int ey;
            ey = (k == 9) ? 2096 : 2096 + k;
            #1;
            chk($sformatf("r2.year%0d", k), int'(year2), ey);
            chk($sformatf("r2.leap%0d", k), int'(leap2), gleap(ey));
            chk($sformatf("r2.bcd%0d", k),  int'(bcd2),  exp_bcd(ey));
            @(negedge clk);
            year_b2 = 1'b1;
            @(posedge clk);
            #1;
            year_b2 = 1'b0;
        end
        chk("r2.month", int'(month2), 1);
        chk("r2.end_year", int'(end_year2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_thang_nam
`default_nettype wire
